// File: rtl/kmeans_acc_block_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : kmeans_acc_block_param_if
//  Purpose  : Sample-in / centroid-drain bundle for the k-means accumulator.
//             The slave side is the accumulator. The master side is the
//             surrounding pipeline, which supplies samples and consumes
//             drain records.
//  Revision : 1.0 - initial release
// ============================================================================
interface kmeans_acc_block_param_if #(
    parameter int centroid_qty_bits        = 2,
    parameter int dims                     = 2,
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16
) ();

    // Phase control
    logic                                  start;
    logic                                  busy;
    logic                                  done;

    // Sample input from the distance pipeline
    logic                                  in_valid;
    logic                                  in_last;
    logic [dims*input_data_width-1:0]      in_data;
    logic [centroid_qty_bits-1:0]          in_centroid;

    // Drain output to the centroid-update stage
    logic                                  out_valid;
    logic                                  out_ready;
    logic [centroid_qty_bits-1:0]          out_centroid;
    logic [dims*acc_width-1:0]             out_acc;
    logic [input_data_qty_bit_width:0]     out_count;
    logic                                  out_empty;
    logic                                  out_overflow;

    modport master (
        output start, in_valid, in_last, in_data, in_centroid, out_ready,
        input  busy, done, out_valid, out_centroid, out_acc, out_count,
               out_empty, out_overflow
    );

    modport slave (
        input  start, in_valid, in_last, in_data, in_centroid, out_ready,
        output busy, done, out_valid, out_centroid, out_acc, out_count,
               out_empty, out_overflow
    );

endinterface
`default_nettype wire

// File: rtl/kmeans_acc_block_param.sv
`default_nettype none
// ============================================================================
//  Module   : kmeans_acc_block_param
//  Purpose  : Parametrised k-means centroid accumulator. It sums samples per
//             centroid and per dimension, with saturating sums and counts and
//             sticky overflow flags. After the last sample it drains one
//             record per centroid through a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module kmeans_acc_block_param #(
    parameter int centroid_qty_bits        = 2,
    parameter int dims                     = 2,
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    kmeans_acc_block_param_if.slave   bus
);

    // acc_width must be at least input_data_width. A single sample is
    // zero-extended and added, so the carry-out bit alone flags overflow.
    localparam int k_qty     = 1 << centroid_qty_bits;
    localparam int cnt_width = input_data_qty_bit_width + 1;
    localparam int pad_width = acc_width + 1 - input_data_width;
    localparam logic [centroid_qty_bits-1:0] last_idx = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [centroid_qty_bits-1:0]    drain_idx;

    logic                            clear;
    logic                            accept;
    logic                            fire;
    logic                            draining;

    // Per-centroid views of the storage, used by the drain multiplexer
    logic [dims*acc_width-1:0]       acc_row [k_qty];
    logic [cnt_width-1:0]            cnt_row [k_qty];
    logic [k_qty-1:0]                ovf_row;

    assign clear    = (state == IDLE)  && bus.start;
    assign accept   = (state == ACC)   && bus.in_valid;
    assign draining = (state == DRAIN);
    assign fire     = draining && bus.out_ready;

    // Phase state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase transitions: start -> accumulate -> drain K records -> done pulse
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start)                        state_next = ACC;
            ACC:     if (bus.in_valid && bus.in_last)      state_next = DRAIN;
            DRAIN:   if (bus.out_ready && drain_idx == last_idx) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Drain index: rewinds on the last sample and advances on each handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_idx <= '0;
        end else if (accept && bus.in_last) begin
            drain_idx <= '0;
        end else if (fire) begin
            drain_idx <= drain_idx + 1'b1;
        end
    end

    for (genvar k = 0; k < k_qty; k++) begin : g_cent
        logic                       hit;
        logic                       cnt_full;
        logic [dims-1:0]            dim_ovf;
        logic [dims*acc_width-1:0]  acc_q;
        logic [dims*acc_width-1:0]  acc_d;
        logic [cnt_width-1:0]       cnt_q;
        logic                       ovf_q;

        assign hit      = accept && (bus.in_centroid == centroid_qty_bits'(k));
        assign cnt_full = &cnt_q;

        for (genvar d = 0; d < dims; d++) begin : g_dim
            logic [acc_width:0] data_ext;
            logic [acc_width:0] sum;

            assign data_ext = {{pad_width{1'b0}},
                               bus.in_data[d*input_data_width +: input_data_width]};
            assign sum      = {1'b0, acc_q[d*acc_width +: acc_width]} + data_ext;
            assign dim_ovf[d] = sum[acc_width];
            assign acc_d[d*acc_width +: acc_width] =
                sum[acc_width] ? {acc_width{1'b1}} : sum[acc_width-1:0];
        end

        // Single-cycle read-modify-write of this centroid's sums, count and flag
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (clear) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (hit) begin
                acc_q <= acc_d;
                if (!cnt_full) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if ((|dim_ovf) || cnt_full) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        assign acc_row[k] = acc_q;
        assign cnt_row[k] = cnt_q;
        assign ovf_row[k] = ovf_q;
    end

    // Drain record is read straight from storage and is forced to zero outside DRAIN
    assign bus.out_valid    = draining;
    assign bus.out_centroid = draining ? drain_idx          : '0;
    assign bus.out_acc      = draining ? acc_row[drain_idx] : '0;
    assign bus.out_count    = draining ? cnt_row[drain_idx] : '0;
    assign bus.out_empty    = draining && (cnt_row[drain_idx] == '0);
    assign bus.out_overflow = draining && ovf_row[drain_idx];
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);

endmodule
`default_nettype wire
